// File: rtl/fsm_pulse_counter.sv
// Counts advance events through STATE_NUM states, firing a one-cycle pulse on wrap to Idle.
// Optional inactivity timeout back to Idle is built only when FSM_TIMEOUT_EN is defined.
module fsm_pulse_counter #(
  parameter int STATE_NUM = 5,
  parameter int MODE      = 0,
  parameter int TIMEOUT   = 16,
  localparam int CNT_W    = (STATE_NUM > 2) ? $clog2(STATE_NUM) : 1
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             FSM_en,
  input  logic             FSM_clr,
  input  logic             FSM_in,
  output logic             FSM_out,
  output logic [CNT_W-1:0] FSM_state,
  output logic             FSM_busy,
  output logic             FSM_timeout
);

  localparam logic [CNT_W-1:0] S_IDLE = '0;
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(STATE_NUM - 1);

  if (STATE_NUM < 2 || STATE_NUM > 256) begin : g_bad_state_num
    $error("fsm_pulse_counter: STATE_NUM out of range 2..256");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("fsm_pulse_counter: TIMEOUT out of range 1..65535");
  end

  logic [CNT_W-1:0] state;
  logic             out_q;
  logic             in_d;
  logic             adv;

  // Edge mode qualifies with the previous input sample so a held level advances once.
  assign adv = (MODE == 1) ? (FSM_en & FSM_in & ~in_d) : (FSM_en & FSM_in);

`ifdef FSM_TIMEOUT_EN
  logic [15:0] cnt;
  logic        to_q;
  logic        to_hit;

  assign to_hit = (state != S_IDLE) && (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= 1'b0;
      if (FSM_clr || adv || state == S_IDLE) begin
        cnt <= '0;
      end else if (to_hit) begin
        cnt  <= '0;
        to_q <= 1'b1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign FSM_timeout = to_q;
`else
  assign FSM_timeout = 1'b0;
`endif

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      out_q <= 1'b0;
      in_d  <= 1'b0;
    end else begin
      in_d  <= FSM_in;
      out_q <= 1'b0;
      if (FSM_clr) begin
        state <= S_IDLE;
      end else if (adv) begin
        if (state == S_LAST) begin
          state <= S_IDLE;
          out_q <= 1'b1;
        end else begin
          state <= state + CNT_W'(1);
        end
      end
`ifdef FSM_TIMEOUT_EN
      else if (to_hit) begin
        state <= S_IDLE;
      end
`endif
    end
  end

  assign FSM_state = state;
  assign FSM_out   = out_q;
  assign FSM_busy  = (state != S_IDLE);

endmodule

// File: doc/fsm_pulse_counter.md
Name: fsm_pulse_counter

Overview:
- Parametrised successor to the fixed five-state input-driven FSM.
- Counts advance events on a 1-bit input through STATE_NUM states (Idle = state 0).
- On wrap back to Idle, emits a one-cycle output pulse.
- Adds:
  - level or rising-edge counting mode;
  - enable and synchronous clear;
  - exposed state and busy flag;
  - optional inactivity timeout.
- Used as a generic "N events then fire" sequencer in the control path.

Parameters:
- STATE_NUM, 5, number of states including Idle; legal range 2..256.
- MODE, 0, 0 = level mode (every enabled cycle with FSM_in=1 advances); 1 = edge mode (only a 0->1 transition of FSM_in advances).
- TIMEOUT, 16, cycles a non-Idle state may persist without an advance before falling back to Idle; legal range 1..65535; used only with FSM_TIMEOUT_EN.

Ports:
- Clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, asynchronous active-high reset.
- FSM_en, input, 1, advance qualifier; 0 freezes counting (timeout still runs).
- FSM_clr, input, 1, synchronous clear to Idle.
- FSM_in, input, 1, event input.
- FSM_out, output, 1, registered one-cycle pulse on wrap to Idle.
- FSM_state, output, CNT_W, current state index; CNT_W = max(1, clog2(STATE_NUM)).
- FSM_busy, output, 1, high when FSM_state != 0.
- FSM_timeout, output, 1, registered one-cycle pulse on timeout fallback; constant 0 without the macro.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high on port rst.
- While rst=1, all of the following are 0: FSM_state, FSM_out, FSM_busy, FSM_timeout, the in_d history register and the timeout counter. After deassertion, the first edge evaluates normally.
- Advance event:
  - adv = FSM_en & FSM_in when MODE=0.
  - adv = FSM_en & FSM_in & ~in_d when MODE=1.
  - in_d <= FSM_in on every edge, regardless of FSM_en or FSM_clr.
- Priority at each edge: FSM_clr > adv > timeout.
- FSM_clr=1:
  - FSM_state <= 0; FSM_out <= 0; FSM_timeout <= 0; counter <= 0.
  - Any coincident adv is discarded.
- adv=1 with state s < STATE_NUM-1: state <= s+1; FSM_out <= 0.
- adv=1 with state s = STATE_NUM-1: state <= 0; FSM_out <= 1.
  - Pulse is visible in the same cycle FSM_state first reads 0.
  - Latency: one edge from the sampled adv.
- No adv and no clear: state holds; FSM_out <= 0.
- FSM_out never stays high more than one cycle unless adv wraps again.
  - Back-to-back wraps are possible only with STATE_NUM=2 in level mode, giving a 1-cycle gap.
- FSM_busy is combinational from FSM_state.
- STATE_NUM=2 degenerate case: every second advance wraps.

Optional Feature:
- Macro: FSM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter resets to 0 on adv, on clear, and while state=0; otherwise it increments each edge.
  - At an edge where state!=0, no adv, no clear and counter==TIMEOUT-1: state <= 0, counter <= 0, FSM_timeout <= 1 for one cycle, FSM_out stays 0.
  - Net effect: a non-Idle state with no advance lasts exactly TIMEOUT cycles.
  - adv on the same edge wins; the timeout does not fire.
- Undefined:
  - No counter logic.
  - FSM_timeout tied to 0.
  - Non-Idle states hold indefinitely.

Test Plan:
1. Level mode, STATE_NUM=5, FSM_en=1, FSM_in=1 for 5 cycles after reset release -> FSM_state reads 1,2,3,4,0; FSM_out=1 only in the cycle state returns to 0; FSM_busy=0 afterwards.
2. Edge mode, STATE_NUM=5, FSM_in held 1 for 5 cycles then 0 -> state reaches 1 and stays 1. Then four 1-cycle pulses separated by 0 -> states 2,3,4,0, with one FSM_out pulse.
3. FSM_en=0 with FSM_in=1 for 10 cycles -> state holds 0, FSM_out=0. FSM_en=1 again -> counting resumes from the held state.
4. Level mode, state=3, assert FSM_clr and FSM_in together -> next state 0, no FSM_out. Assert rst mid-count asynchronously between edges -> state 0 immediately, before the next Clk edge.
5. With FSM_TIMEOUT_EN, TIMEOUT=4: advance to state 2, then FSM_in=0 -> state 2 for exactly 4 cycles, then 0, with one FSM_timeout pulse and FSM_out=0. Repeat with an adv on the 4th edge -> state 3, no timeout.
6. STATE_NUM=2, level mode, FSM_in=1 for 6 cycles -> state toggles 1,0,1,0,1,0; FSM_out pulses 3 times.
